// File: rtl/eth_tx_framer_if.sv
// eth_tx_framer_if: groups the framer's header-write port, frame request,
// upstream show-ahead FIFO port and PHY-side byte stream.
//   master : upstream/driver side (drives i_*, observes o_*)
//   slave  : the framer (observes i_*, drives o_*)
interface eth_tx_framer_if;
    logic [3:0]  i_hdr_idx;    // header byte offset 0..13
    logic [7:0]  i_hdr_byte;   // byte to store at i_hdr_idx
    logic        i_hdr_wr_en;  // header write strobe
    logic        i_start;      // frame request
    logic [10:0] i_len;        // payload length, captured on start
    logic [7:0]  i_pl_byte;    // FIFO head byte (show-ahead)
    logic        o_pl_rd;      // FIFO pop
    logic [7:0]  o_tx_data;    // frame byte
    logic        o_tx_en;      // o_tx_data valid
    logic        o_busy;       // frame in progress (incl. IFG)
    logic        o_done;       // one-cycle pulse on return to idle

    modport master (
        output i_hdr_idx, i_hdr_byte, i_hdr_wr_en, i_start, i_len, i_pl_byte,
        input  o_pl_rd, o_tx_data, o_tx_en, o_busy, o_done
    );

    modport slave (
        input  i_hdr_idx, i_hdr_byte, i_hdr_wr_en, i_start, i_len, i_pl_byte,
        output o_pl_rd, o_tx_data, o_tx_en, o_busy, o_done
    );
endinterface

// File: rtl/eth_tx_framer.sv
// eth_tx_framer: streams one Ethernet frame per start request:
// 7x 0x55 preamble, 0xD5 SFD, 14-byte header buffer, payload popped from a
// show-ahead FIFO, zero pad up to a 46-byte data field, optional FCS, then
// IFG_CYCLES idle cycles.
//
// Ports:
//   i_clk   sole clock
//   i_rst   asynchronous active-high reset
//   bus     eth_tx_framer_if.slave (header write, start/len, FIFO, tx bytes)
//
// Optional feature: define ETH_TX_FCS_EN to append the CRC-32 FCS (over
// header, payload and pad, LSB first).
//
// The FSM runs one cycle ahead of the wire: each cycle it selects the byte
// that the output register presents on the next cycle. The accept cycle in
// IDLE therefore already emits the first preamble byte, and a payload byte
// popped in a PAY cycle shows up on o_tx_data one cycle later.
module eth_tx_framer #(
    parameter int IFG_CYCLES  = 12,
    parameter int MAX_PAYLOAD = 1500
) (
    input  logic          i_clk,
    input  logic          i_rst,
    eth_tx_framer_if.slave bus
);

`ifdef ETH_TX_FCS_EN
    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_HDR, S_PAY, S_PAD, S_FCS, S_IFG
    } state_t;
    localparam state_t S_DATA_END = S_FCS;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_HDR, S_PAY, S_PAD, S_IFG
    } state_t;
    localparam state_t S_DATA_END = S_IFG;
`endif

    localparam logic [10:0] MAX_LEN  = 11'(MAX_PAYLOAD);
    localparam logic [10:0] IFG_LAST = 11'(IFG_CYCLES);
    localparam logic [10:0] MIN_DATA = 11'd46;

    state_t            state_q, state_d;
    logic [10:0]       cnt_q;
    logic [10:0]       len_q;
    logic [13:0][7:0]  hdr_q;
    logic [7:0]        tx_data_q;
    logic              tx_en_q;
    logic              done_q;

    logic [7:0]        tx_byte;
    logic              tx_vld;
    logic              pl_rd;
    logic              accept;

    assign accept = (state_q == S_IDLE) && bus.i_start;

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            // Counter restarts on every state entry; idle holds it at zero.
            if (state_d != state_q || state_q == S_IDLE)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + 11'd1;
        end
    end

    // ---------------- next-state logic ----------------
    // Each state leaves on its last byte so o_tx_en never gaps.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.i_start) state_d = S_PRE;
            // Accept cycle emitted preamble byte 0; PRE supplies the other six.
            S_PRE:  if (cnt_q == 11'd5) state_d = S_SFD;
            S_SFD:  state_d = S_HDR;
            S_HDR:  if (cnt_q == 11'd13) state_d = (len_q == '0) ? S_PAD : S_PAY;
            S_PAY:  if (cnt_q == len_q - 11'd1)
                        state_d = (len_q >= MIN_DATA) ? S_DATA_END : S_PAD;
            S_PAD:  if (cnt_q == MIN_DATA - 11'd1 - len_q) state_d = S_DATA_END;
`ifdef ETH_TX_FCS_EN
            S_FCS:  if (cnt_q == 11'd3) state_d = S_IFG;
`endif
            // One extra cycle: the output register still holds the last
            // frame byte during the first IFG cycle of the FSM.
            S_IFG:  if (cnt_q == IFG_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef ETH_TX_FCS_EN
    logic [31:0] crc_q;
    logic [31:0] fcs;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign fcs = ~crc_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            crc_q <= '1;
        else if (accept)
            crc_q <= '1;
        else if (state_q == S_HDR || state_q == S_PAY || state_q == S_PAD)
            crc_q <= crc32_byte(crc_q, tx_byte);
    end
`endif

    // ---------------- output logic ----------------
    always_comb begin
        tx_byte = 8'h00;
        tx_vld  = 1'b0;
        pl_rd   = 1'b0;
        case (state_q)
            S_IDLE: if (bus.i_start) begin tx_byte = 8'h55; tx_vld = 1'b1; end
            S_PRE:  begin tx_byte = 8'h55; tx_vld = 1'b1; end
            S_SFD:  begin tx_byte = 8'hD5; tx_vld = 1'b1; end
            S_HDR:  begin tx_byte = hdr_q[cnt_q[3:0]]; tx_vld = 1'b1; end
            S_PAY:  begin tx_byte = bus.i_pl_byte; tx_vld = 1'b1; pl_rd = 1'b1; end
            S_PAD:  begin tx_byte = 8'h00; tx_vld = 1'b1; end
`ifdef ETH_TX_FCS_EN
            S_FCS:  begin tx_byte = fcs[{cnt_q[1:0], 3'b000} +: 8]; tx_vld = 1'b1; end
`endif
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hdr_q     <= '0;
            len_q     <= '0;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (bus.i_hdr_wr_en && state_q == S_IDLE && bus.i_hdr_idx <= 4'd13)
                hdr_q[bus.i_hdr_idx] <= bus.i_hdr_byte;
            if (accept)
                len_q <= (bus.i_len > MAX_LEN) ? MAX_LEN : bus.i_len;
            tx_data_q <= tx_byte;
            tx_en_q   <= tx_vld;
            done_q    <= (state_q == S_IFG) && (state_d == S_IDLE);
        end
    end

    assign bus.o_pl_rd   = pl_rd;
    assign bus.o_tx_data = tx_data_q;
    assign bus.o_tx_en   = tx_en_q;
    assign bus.o_busy    = (state_q != S_IDLE);
    assign bus.o_done    = done_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer: table-driven directed frames, hand-written corner
// sequences, and random frames compared against a byte-queue frame model.
module tb_eth_tx_framer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eth_tx_framer_if bus();

    eth_tx_framer #(.IFG_CYCLES(12), .MAX_PAYLOAD(1500)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

`ifdef ETH_TX_FCS_EN
    localparam int FCS_N = 4;
`else
    localparam int FCS_N = 0;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] mdl_hdr [14];
    logic [7:0] pay_mem [2048];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];

    typedef struct {
        int len;
        int exp_en;
        int exp_pops;
    } vec_t;
    vec_t tbl [7];

    task automatic check(input string name, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Reference frame: preamble, SFD, header, payload, pad to 46, FCS.
    function automatic void build_exp(input int len_in);
        int len;
        logic [31:0] c;
        len = (len_in > 1500) ? 1500 : len_in;
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 14; i++) exp_q.push_back(mdl_hdr[i]);
        for (int i = 0; i < len; i++) exp_q.push_back(pay_mem[i]);
        for (int i = len; i < 46; i++) exp_q.push_back(8'h00);
        if (FCS_N != 0) begin
            c = 32'hFFFFFFFF;
            for (int i = 8; i < exp_q.size(); i++) begin
                c = c ^ {24'd0, exp_q[i]};
                for (int b = 0; b < 8; b++)
                    c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
            c = ~c;
            for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
        end
    endfunction

    task automatic fill_payload();
        for (int i = 0; i < 2048; i++) pay_mem[i] = 8'($urandom);
    endtask

    task automatic hdr_wr(input int idx, input logic [7:0] b);
        @(negedge clk);
        bus.i_hdr_wr_en = 1'b1;
        bus.i_hdr_idx   = 4'(idx);
        bus.i_hdr_byte  = b;
        @(negedge clk);
        bus.i_hdr_wr_en = 1'b0;
        if (idx <= 13) mdl_hdr[idx] = b;
    endtask

    // Runs one frame, models the FIFO, and checks it against the model.
    // sc_idx >= 0 applies a header write in the same cycle as the start.
    // inject issues an ignored header write + start in the middle of the frame.
    task automatic run_frame(input string tag, input int len_in, input bit inject,
                             input int sc_idx, input logic [7:0] sc_byte,
                             output int en_cnt, output int pops);
        int cyc, first_en, last_en, done_cyc, gaps, busy_bad, pidx, bad, exp_pops;
        bit rd_prev;
        if (sc_idx >= 0 && sc_idx <= 13) mdl_hdr[sc_idx] = sc_byte;
        build_exp(len_in);
        exp_pops = (len_in > 1500) ? 1500 : len_in;
        @(negedge clk);
        bus.i_len     = 11'(len_in);
        bus.i_start   = 1'b1;
        pidx          = 0;
        bus.i_pl_byte = pay_mem[0];
        if (sc_idx >= 0) begin
            bus.i_hdr_wr_en = 1'b1;
            bus.i_hdr_idx   = 4'(sc_idx);
            bus.i_hdr_byte  = sc_byte;
        end
        @(negedge clk);
        bus.i_start     = 1'b0;
        bus.i_hdr_wr_en = 1'b0;
        got_q.delete();
        cyc = 1; en_cnt = 0; pops = 0; first_en = -1; last_en = -1;
        done_cyc = -1; gaps = 0; busy_bad = 0; rd_prev = 1'b0;
        while (cyc < 2200) begin
            if (rd_prev) begin
                pidx++;
                bus.i_pl_byte = pay_mem[pidx % 2048];
            end
            rd_prev = bus.o_pl_rd;
            if (rd_prev) pops++;
            if (bus.o_tx_en) begin
                got_q.push_back(bus.o_tx_data);
                en_cnt++;
                if (first_en < 0) first_en = cyc;
                if (last_en >= 0 && last_en != cyc - 1) gaps++;
                last_en = cyc;
            end
            if (bus.o_done) begin
                done_cyc = cyc;
                if (bus.o_busy) busy_bad++;
                break;
            end else if (!bus.o_busy) busy_bad++;
            if (inject && cyc == 30) begin
                bus.i_hdr_wr_en = 1'b1;
                bus.i_hdr_idx   = 4'd3;
                bus.i_hdr_byte  = ~mdl_hdr[3];
                bus.i_start     = 1'b1;
            end else if (inject && cyc == 31) begin
                bus.i_hdr_wr_en = 1'b0;
                bus.i_start     = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        check({tag, " en_cycles"}, en_cnt, exp_q.size());
        check({tag, " first_en_cycle"}, first_en, 1);
        check({tag, " data_byte_errors"}, bad, 0);
        check({tag, " pops"}, pops, exp_pops);
        check({tag, " en_gaps"}, gaps, 0);
        check({tag, " busy_errors"}, busy_bad, 0);
        check({tag, " done_after_en_fall"}, (done_cyc < 0) ? -1 : done_cyc - (last_en + 1), 12);
    endtask

    initial begin
        int en, pp, t;

        tbl[0] = '{46,   68 + FCS_N,   46};
        tbl[1] = '{10,   68 + FCS_N,   10};
        tbl[2] = '{0,    68 + FCS_N,   0};
        tbl[3] = '{2000, 1522 + FCS_N, 1500};
        tbl[4] = '{60,   82 + FCS_N,   60};
        tbl[5] = '{45,   68 + FCS_N,   45};
        tbl[6] = '{47,   69 + FCS_N,   47};

        for (int i = 0; i < 14; i++) mdl_hdr[i] = 8'h00;
        bus.i_hdr_idx = '0; bus.i_hdr_byte = '0; bus.i_hdr_wr_en = 1'b0;
        bus.i_start = 1'b0; bus.i_len = '0; bus.i_pl_byte = '0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst tx_en",   bus.o_tx_en, 0);
        check("rst tx_data", bus.o_tx_data, 0);
        check("rst busy",    bus.o_busy, 0);
        check("rst done",    bus.o_done, 0);
        check("rst pl_rd",   bus.o_pl_rd, 0);
        rst = 1'b0;

        // Header buffer starts cleared; all-zero 60-byte data field.
        for (int i = 0; i < 2048; i++) pay_mem[i] = 8'h00;
        run_frame("zero_hdr60", 60, 1'b0, -1, 8'h00, en, pp);

        // dst MAC 02:00:00:00:00:01, type 0x0800
        hdr_wr(0, 8'h02); hdr_wr(1, 8'h00); hdr_wr(2, 8'h00);
        hdr_wr(3, 8'h00); hdr_wr(4, 8'h00); hdr_wr(5, 8'h01);
        hdr_wr(12, 8'h08); hdr_wr(13, 8'h00);

        for (int v = 0; v < 7; v++) begin
            fill_payload();
            run_frame($sformatf("tbl%0d", v), tbl[v].len, 1'b0, -1, 8'h00, en, pp);
            check($sformatf("tbl%0d en_const", v), en, tbl[v].exp_en);
            check($sformatf("tbl%0d pops_const", v), pp, tbl[v].exp_pops);
        end

        // Writes to idx 14/15 are dropped.
        hdr_wr(14, 8'hEE);
        hdr_wr(15, 8'h77);
        fill_payload();
        run_frame("idx14_15", 20, 1'b0, -1, 8'h00, en, pp);

        // Mid-frame header write and start are ignored; no re-trigger.
        fill_payload();
        run_frame("mid_inject", 50, 1'b1, -1, 8'h00, en, pp);
        t = 0;
        repeat (3) begin @(negedge clk); if (bus.o_busy) t++; end
        check("mid_inject no_retrigger", t, 0);
        fill_payload();
        run_frame("after_inject", 12, 1'b0, -1, 8'h00, en, pp);

        // Write and start in the same cycle: frame uses the new byte.
        fill_payload();
        run_frame("same_cycle_wr", 30, 1'b0, 5, 8'h5A, en, pp);

        // i_start held high re-triggers right after o_done.
        @(negedge clk);
        bus.i_len = 11'd0; bus.i_start = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.o_done && t < 300);
        check("retrig done_seen", bus.o_done, 1);
        check("retrig busy_at_done", bus.o_busy, 0);
        @(negedge clk);
        check("retrig busy_next", bus.o_busy, 1);
        check("retrig en_next", bus.o_tx_en, 1);
        check("retrig data_next", bus.o_tx_data, 8'h55);
        bus.i_start = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.o_done && t < 300);
        check("retrig second_done", bus.o_done, 1);

        // Reset during PAY aborts immediately.
        @(negedge clk);
        bus.i_len = 11'd100; bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        t = 0;
        while (!bus.o_pl_rd && t < 100) begin @(negedge clk); t++; end
        check("rstpay reached_pay", bus.o_pl_rd, 1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstpay tx_en", bus.o_tx_en, 0);
        check("rstpay pl_rd", bus.o_pl_rd, 0);
        check("rstpay busy",  bus.o_busy, 0);
        check("rstpay tx_data", bus.o_tx_data, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 14; i++) mdl_hdr[i] = 8'h00;
        fill_payload();
        run_frame("post_rst", 25, 1'b0, -1, 8'h00, en, pp);

        // Random frames with random header updates.
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 3; k++)
                hdr_wr($urandom_range(0, 15), 8'($urandom));
            fill_payload();
            run_frame($sformatf("rand%0d", r), $urandom_range(0, 120), 1'b0,
                      ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : -1,
                      8'($urandom), en, pp);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
